fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined processor.
- Owns the PC and drives the imem address. The imem is clocked on the inverted clock, so the instruction returns within the same cycle.
- Captures {PC+1, instruction} into the F/D pipeline latch consumed by decode.
- Obeys stall from the hazard unit and redirect (taken branch / jump / jr) from execute.

---
 rtl/proc_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 41 ++++
 rtl/fetch_stage_dffe_reg.sv | 37 +++
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared processor types and defaults used by the pipeline stages.
// Combinational only: no latency.
// No flow control.
package proc_pkg;

    localparam int ADDR_W = 12;
    localparam int INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0000;

    // F/D pipeline latch contents, also consumed by the decode stage
    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] pc_plus1;
        logic              valid;
    } fd_latch_t;

    // Sequential PC increment; wraps modulo 2^ADDR_W with no flag
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/execute controls, imem port, F/D latch outputs.
// Wires only: no latency.
// Optional FETCH_PERF_CNT_EN adds the three performance counter outputs.
interface fetch_stage_if #(
    parameter int ADDR_W = proc_pkg::ADDR_W,
    parameter int INSN_W = proc_pkg::INSN_W
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] address_imem;
    logic [INSN_W-1:0] q_imem;
    logic [INSN_W-1:0] fd_insn;
    logic [ADDR_W-1:0] fd_pc_plus1;
    logic              fd_valid;
    logic              flush_fd;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetch_cnt;
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_flush_cnt;
`endif

    // Fetch stage side
    modport master (
`ifdef FETCH_PERF_CNT_EN
        output perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt,
`endif
        input  stall, redirect, redirect_target, q_imem,
        output address_imem, fd_insn, fd_pc_plus1, fd_valid, flush_fd
    );

    // Surrounding pipeline / imem side
    modport slave (
`ifdef FETCH_PERF_CNT_EN
        input  perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt,
`endif
        output stall, redirect, redirect_target, q_imem,
        input  address_imem, fd_insn, fd_pc_plus1, fd_valid, flush_fd
    );

endinterface

// File: rtl/fetch_stage_dffe_reg.sv
// Generic register with synchronous active-high reset, load enable and reset value.
// One cycle: d appears on q after the posedge where en=1.
// en=0 holds the current value.
module dffe_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value: load when enabled, otherwise hold
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    // State register; reset takes priority over enable
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, drives imem address, captures {PC+1, insn} into F/D.
// imem address is combinational from pc; F/D updates one posedge after fetch.
// stall freezes PC and F/D; redirect overrides stall and flushes F/D. Optional FETCH_PERF_CNT_EN.
module fetch_stage
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = proc_pkg::ADDR_W,
    parameter int                INSN_W   = proc_pkg::INSN_W,
    parameter logic [INSN_W-1:0] NOP_INSN = proc_pkg::NOP_INSN
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.master fif
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    fd_latch_t         fd_q;
    fd_latch_t         fd_d;
    logic              upd_en;

    assign pc_plus1 = pc_inc(pc_q);

    // Next PC / F/D selection: redirect > stall > sequential fetch
    always_comb begin
        upd_en         = 1'b1;
        pc_d           = pc_plus1;
        fd_d.insn      = fif.q_imem;
        fd_d.pc_plus1  = pc_plus1;
        fd_d.valid     = 1'b1;
        if (fif.redirect) begin
            // The word fetched this cycle is on the wrong path; drop it
            pc_d          = fif.redirect_target;
            fd_d.insn     = NOP_INSN;
            fd_d.pc_plus1 = '0;
            fd_d.valid    = 1'b0;
        end else if (fif.stall) begin
            upd_en = 1'b0;
            pc_d   = pc_q;
            fd_d   = fd_q;
        end
    end

    dffe_reg #(.WIDTH(ADDR_W), .RST_VAL('0)) u_pc_reg (
        .clock (clock),
        .reset (reset),
        .en    (upd_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    dffe_reg #(.WIDTH(INSN_W), .RST_VAL(NOP_INSN)) u_fd_insn_reg (
        .clock (clock),
        .reset (reset),
        .en    (upd_en),
        .d     (fd_d.insn),
        .q     (fd_q.insn)
    );

    dffe_reg #(.WIDTH(ADDR_W), .RST_VAL('0)) u_fd_pc_plus1_reg (
        .clock (clock),
        .reset (reset),
        .en    (upd_en),
        .d     (fd_d.pc_plus1),
        .q     (fd_q.pc_plus1)
    );

    dffe_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_fd_valid_reg (
        .clock (clock),
        .reset (reset),
        .en    (upd_en),
        .d     (fd_d.valid),
        .q     (fd_q.valid)
    );

    // pc_q may be stale during the first reset cycle, so force the address to 0
    assign fif.address_imem = reset ? '0 : pc_q;
    assign fif.flush_fd     = fif.redirect & ~reset;
    assign fif.fd_insn      = fd_q.insn;
    assign fif.fd_pc_plus1  = fd_q.pc_plus1;
    assign fif.fd_valid     = fd_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_fetch_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_flush_d;

    // Exactly one of the three counters advances per non-reset cycle
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (fif.redirect) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end else if (fif.stall) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset, wrap at 2^32
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign fif.perf_fetch_cnt = perf_fetch_q;
    assign fif.perf_stall_cnt = perf_stall_q;
    assign fif.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then random control against a reference model.
// imem modelled as a combinational array read at address_imem.
// Optional FETCH_PERF_CNT_EN section checks the counters.
module tb_fetch_stage;

    localparam int AW = 12;

    logic clock;
    logic reset;

    fetch_stage_if #(.ADDR_W(AW), .INSN_W(32)) fif ();

    fetch_stage u_dut (
        .clock (clock),
        .reset (reset),
        .fif   (fif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [31:0] imem [0:4095];
    always_comb fif.q_imem = imem[fif.address_imem];

    int vectors;
    int miscompares;

    typedef struct {
        logic        r;
        logic        s;
        logic        rd;
        logic [11:0] tgt;
        logic [11:0] e_addr;
        logic        e_flush;
        logic [31:0] e_insn;
        logic [11:0] e_pcp1;
        logic        e_valid;
    } vec_t;

    vec_t tbl[$];

    // Reference model: architectural state following the stage's rules
    logic [11:0] m_pc;
    logic [31:0] m_insn;
    logic [11:0] m_pcp1;
    logic        m_valid;
    logic [31:0] m_nfetch, m_nstall, m_nflush;

    always @(posedge clock) begin
        if (reset) begin
            m_pc <= 12'd0; m_insn <= 32'd0; m_pcp1 <= 12'd0; m_valid <= 1'b0;
            m_nfetch <= 0; m_nstall <= 0; m_nflush <= 0;
        end else if (fif.redirect) begin
            m_pc <= fif.redirect_target; m_insn <= 32'd0; m_pcp1 <= 12'd0; m_valid <= 1'b0;
            m_nflush <= m_nflush + 1;
        end else if (fif.stall) begin
            m_nstall <= m_nstall + 1;
        end else begin
            m_insn  <= imem[m_pc];
            m_pc    <= 12'((int'(m_pc) + 1) % 4096);
            m_pcp1  <= 12'((int'(m_pc) + 1) % 4096);
            m_valid <= 1'b1;
            m_nfetch <= m_nfetch + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, s, rd, input logic [11:0] tgt,
                                input logic [11:0] ea, input logic ef,
                                input logic [31:0] ei, input logic [11:0] ep, input logic ev);
        vec_t v;
        v.r = r; v.s = s; v.rd = rd; v.tgt = tgt;
        v.e_addr = ea; v.e_flush = ef; v.e_insn = ei; v.e_pcp1 = ep; v.e_valid = ev;
        return v;
    endfunction

    // Drive one cycle; check combinational outputs mid-cycle, registered ones after the edge
    task automatic apply(input vec_t v, input bit use_model);
        logic [11:0] ea;
        logic        ef;
        reset = v.r; fif.stall = v.s; fif.redirect = v.rd; fif.redirect_target = v.tgt;
        ea = use_model ? (v.r ? 12'd0 : m_pc) : v.e_addr;
        ef = use_model ? (v.rd && !v.r) : v.e_flush;
        #4;
        chk("address_imem", 32'(fif.address_imem), 32'(ea));
        chk("flush_fd", 32'(fif.flush_fd), 32'(ef));
        @(posedge clock);
        #1;
        if (use_model) begin
            chk("fd_insn", fif.fd_insn, m_insn);
            chk("fd_pc_plus1", 32'(fif.fd_pc_plus1), 32'(m_pcp1));
            chk("fd_valid", 32'(fif.fd_valid), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch_cnt", fif.perf_fetch_cnt, m_nfetch);
            chk("perf_stall_cnt", fif.perf_stall_cnt, m_nstall);
            chk("perf_flush_cnt", fif.perf_flush_cnt, m_nflush);
`endif
        end else begin
            chk("fd_insn", fif.fd_insn, v.e_insn);
            chk("fd_pc_plus1", 32'(fif.fd_pc_plus1), 32'(v.e_pcp1));
            chk("fd_valid", 32'(fif.fd_valid), 32'(v.e_valid));
        end
    endtask

    initial begin
        vec_t v;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        fif.stall = 1'b0;
        fif.redirect = 1'b0;
        fif.redirect_target = 12'd0;

        for (int i = 0; i < 4096; i++) imem[i] = $urandom;
        imem[0] = 32'h11; imem[1] = 32'h22; imem[2] = 32'h33;
        imem[3] = 32'h44; imem[4] = 32'h55; imem[5] = 32'h66;
        imem[12'h100] = 32'hABCD_0100;
        imem[12'hFFF] = 32'hDEAD_BFFF;

        //            r  s  rd tgt     addr    fl insn           pcp1    v
        tbl.push_back(mk(1, 0, 0, 12'h000, 12'h000, 0, 32'h0,        12'h000, 0));
        tbl.push_back(mk(1, 0, 0, 12'h000, 12'h000, 0, 32'h0,        12'h000, 0));
        tbl.push_back(mk(1, 0, 0, 12'h000, 12'h000, 0, 32'h0,        12'h000, 0));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 32'h11,       12'h001, 1));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h001, 0, 32'h22,       12'h002, 1));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h002, 0, 32'h33,       12'h003, 1));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h003, 0, 32'h44,       12'h004, 1));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h004, 0, 32'h55,       12'h005, 1));
        tbl.push_back(mk(0, 1, 0, 12'h000, 12'h005, 0, 32'h55,       12'h005, 1));
        tbl.push_back(mk(0, 1, 0, 12'h000, 12'h005, 0, 32'h55,       12'h005, 1));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h005, 0, 32'h66,       12'h006, 1));
        tbl.push_back(mk(0, 1, 1, 12'h100, 12'h006, 1, 32'h0,        12'h000, 0));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h100, 0, 32'hABCD0100, 12'h101, 1));
        tbl.push_back(mk(0, 0, 1, 12'hFFF, 12'h101, 1, 32'h0,        12'h000, 0));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'hFFF, 0, 32'hDEADBFFF, 12'h000, 1));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 32'h11,       12'h001, 1));
        tbl.push_back(mk(0, 0, 1, 12'h001, 12'h001, 1, 32'h0,        12'h000, 0));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h001, 0, 32'h22,       12'h002, 1));
        tbl.push_back(mk(0, 0, 1, 12'h040, 12'h002, 1, 32'h0,        12'h000, 0));
        tbl.push_back(mk(1, 1, 1, 12'h077, 12'h000, 0, 32'h0,        12'h000, 0));
        tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 32'h11,       12'h001, 1));

        foreach (tbl[i]) apply(tbl[i], 1'b0);

        // Random control traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            v = mk(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 6) == 0), 12'($urandom), 12'd0, 1'b0, 32'd0, 12'd0, 1'b0);
            apply(v, 1'b1);
        end

`ifdef FETCH_PERF_CNT_EN
        // Counter sequence: 10 fetches, 3 stalls, 2 redirects after a fresh reset
        apply(mk(1, 0, 0, 12'h0, 12'h0, 0, 32'h0, 12'h0, 0), 1'b1);
        for (int i = 0; i < 10; i++) apply(mk(0, 0, 0, 12'h0, 12'h0, 0, 32'h0, 12'h0, 0), 1'b1);
        for (int i = 0; i < 3; i++)  apply(mk(0, 1, 0, 12'h0, 12'h0, 0, 32'h0, 12'h0, 0), 1'b1);
        for (int i = 0; i < 2; i++)  apply(mk(0, 0, 1, 12'h010, 12'h0, 0, 32'h0, 12'h0, 0), 1'b1);
        chk("perf_fetch_10", fif.perf_fetch_cnt, 32'd10);
        chk("perf_stall_3", fif.perf_stall_cnt, 32'd3);
        chk("perf_flush_2", fif.perf_flush_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
